// File: rtl/vga_pkg.sv
// Shared constants, register map and helpers for the VGA sprite overlay stage.
package vga_pkg;

  localparam int HD = 640;
  localparam int VD = 480;

  localparam logic [4:0] OFS_X    = 5'd16;
  localparam logic [4:0] OFS_Y    = 5'd17;
  localparam logic [4:0] OFS_ATTR = 5'd18;

  localparam int SPRITE_W = 16;
  localparam int SPRITE_H = 16;

  localparam int RGB_R_MSB = 7;
  localparam int RGB_R_LSB = 5;
  localparam int RGB_G_MSB = 4;
  localparam int RGB_G_LSB = 2;
  localparam int RGB_B_MSB = 1;
  localparam int RGB_B_LSB = 0;

  typedef struct packed {
    logic       enable;
    logic [7:0] color;
    logic [9:0] x;
    logic [9:0] y;
  } sprite_attr_t;

  // 11-bit compare so an origin near 1023 cannot wrap back onto column 0.
  function automatic logic in_span(input logic [9:0] pos, input logic [9:0] origin,
                                   input int unsigned size);
    logic [10:0] p;
    logic [10:0] lo;
    logic [10:0] hi;
    p  = {1'b0, pos};
    lo = {1'b0, origin};
    hi = lo + 11'(size);
    return (p >= lo) && (p < hi);
  endfunction

endpackage

// File: rtl/vga_sprite_renderer_if.sv
// Register-write handshake between the game CPU bridge and the sprite renderer.
interface vga_sprite_renderer_if;

  logic        wr_valid;
  logic        wr_ready;
  logic [6:0]  wr_addr;
  logic [15:0] wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);

endinterface

// File: rtl/vga_sprite_renderer_sprite_unit.sv
// One 16x16 one-bit sprite: shadow/active attributes, live bitmap and pipelined hit test.
module sprite_unit
  import vga_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [4:0]  wr_ofs,
  input  logic [15:0] wr_data,
  input  logic        commit,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  output logic        hit,
  output logic [7:0]  color
);

  sprite_attr_t shadow;
  sprite_attr_t active;
  logic [15:0]  bitmap [SPRITE_H];
  logic         in_range_q;
  logic [3:0]   dx_q;
  logic [3:0]   dy_q;

  // Commit and accepted writes never coincide, since the top stalls writes on commit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shadow <= '0;
      active <= '0;
    end else begin
      if (commit) active <= shadow;
      if (wr_en) begin
        case (wr_ofs)
          OFS_X:    shadow.x <= wr_data[9:0];
          OFS_Y:    shadow.y <= wr_data[9:0];
          OFS_ATTR: begin
            shadow.color  <= wr_data[7:0];
            shadow.enable <= wr_data[8];
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < SPRITE_H; r++) bitmap[r] <= '0;
    end else if (wr_en && !wr_ofs[4]) begin
      bitmap[wr_ofs[3:0]] <= wr_data;
    end
  end

  // Low nibble of the offset is all the bitmap lookup needs once the range test passed.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      in_range_q <= 1'b0;
      dx_q       <= '0;
      dy_q       <= '0;
    end else begin
      in_range_q <= active.enable
                    && in_span(pixel_x, active.x, SPRITE_W)
                    && in_span(pixel_y, active.y, SPRITE_H);
      dx_q       <= pixel_x[3:0] - active.x[3:0];
      dy_q       <= pixel_y[3:0] - active.y[3:0];
    end
  end

  assign hit   = in_range_q && bitmap[dy_q][4'd15 - dx_q];
  assign color = active.color;

endmodule

// File: rtl/vga_sprite_renderer.sv
// RGB332 pixel stage: overlays four prioritised sprites on a flat background, sync kept aligned.
module vga_sprite_renderer #(
  parameter int         HD          = vga_pkg::HD,
  parameter int         VD          = vga_pkg::VD,
  parameter logic [7:0] BG_COLOR    = 8'h00,
  parameter int         NUM_SPRITES = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [9:0]                  pixel_x,
  input  logic [9:0]                  pixel_y,
  input  logic                        video_enable,
  input  logic                        hsync_in,
  input  logic                        vsync_in,
  vga_sprite_renderer_if.slave        wr,
  output logic [7:0]                  rgb,
  output logic                        hsync_out,
  output logic                        vsync_out
);

  logic                   commit;
  logic                   wr_fire;
  logic [NUM_SPRITES-1:0] hit;
  logic [7:0]             spr_color [NUM_SPRITES];
  logic [7:0]             pix_color;
  logic                   ve_q;
  logic                   hs_q;
  logic                   vs_q;

  // First pixel of the first blanking line: swap in the next frame's attributes.
  assign commit      = (pixel_x == 10'd0) && (pixel_y == 10'(VD));
  assign wr.wr_ready = reset && !commit;
  assign wr_fire     = wr.wr_valid && wr.wr_ready;

  for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_sprite
    sprite_unit u_sprite (
      .clock   (clock),
      .reset   (reset),
      .wr_en   (wr_fire && (wr.wr_addr[6:5] == 2'(i))),
      .wr_ofs  (wr.wr_addr[4:0]),
      .wr_data (wr.wr_data),
      .commit  (commit),
      .pixel_x (pixel_x),
      .pixel_y (pixel_y),
      .hit     (hit[i]),
      .color   (spr_color[i])
    );
  end

  // Walk from the highest index down so sprite 0 ends up on top.
  always_comb begin
    pix_color = BG_COLOR;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (hit[i]) pix_color = spr_color[i];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ve_q      <= 1'b0;
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
      rgb       <= '0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
    end else begin
      ve_q      <= video_enable && (pixel_x < 10'(HD));
      hs_q      <= hsync_in;
      vs_q      <= vsync_in;
      rgb       <= ve_q ? pix_color : 8'h00;
      hsync_out <= hs_q;
      vsync_out <= vs_q;
    end
  end

endmodule

// File: doc/vga_sprite_renderer.md
# vga_sprite_renderer

Pixel-generation stage directly downstream of the VGA sync generator. Consumes its `pixel_x`/`pixel_y`/`video_enable`/`hsync`/`vsync` and produces RGB332 colour for the DAC. It overlays up to four 16x16 one-bit sprites (robot and target markers for the AR game) on a flat background colour. Sync outputs are delayed to stay aligned with the two-stage colour pipeline. Sprite position, colour and enable are double-buffered and committed once per frame, so a frame is never torn.

## Interface
Parameters:
- `HD`, 640, active horizontal pixels
- `VD`, 480, active lines; commit happens at the start of line `VD`
- `BG_COLOR`, 8'h00, RGB332 background colour
- `NUM_SPRITES`, 4, sprite count (fixed at 4 by the address map)

Ports:
- `clock`  in  1  pixel clock, same domain as the sync generator
- `reset`  in  1  asynchronous, active-low
- `pixel_x`  in  10  current column from the sync generator
- `pixel_y`  in  10  current line from the sync generator
- `video_enable`  in  1  active-area flag
- `hsync_in`, `vsync_in`  in  1 each  sync from the generator
- `wr_valid`  in  1  register-write request
- `wr_ready`  out  1  write accepted when `wr_valid && wr_ready`
- `wr_addr`  in  7  [6:5] sprite index, [4:0] register offset
- `wr_data`  in  16  write data
- `rgb`  out  8  RGB332 pixel: R[7:5], G[4:2], B[1:0]
- `hsync_out`, `vsync_out`  out  1 each  sync delayed by 2 cycles

## Operation
- Register offsets per sprite:
  - 0–15: bitmap row 0–15; bit 15 is the leftmost pixel. Written live to active storage.
  - 16: X, `wr_data[9:0]`, written to shadow.
  - 17: Y, `wr_data[9:0]`, written to shadow.
  - 18: colour `wr_data[7:0]` and enable `wr_data[8]`, written to shadow.
  - 19–31: accepted and ignored.
- Commit:
  - Commit is asserted when `pixel_x == 0 && pixel_y == VD`.
  - In that cycle all shadow X/Y/colour/enable are copied to the active set.
- Write handshake:
  - `wr_ready = reset && !commit`, combinational.
  - A write is never dropped; the writer holds `wr_valid` across the stall.
- Sprite hit:
  - Sprite i hits when enabled, `pixel_x - X` lies in 0..15 and `pixel_y - Y` lies in 0..15, and the selected bitmap bit is 1.
  - Comparisons use 11-bit unsigned arithmetic (`X+15` up to 1038, no wrap).
  - A sprite extending past the active area is clipped by `video_enable`.
- Priority: the lowest index wins. Sprite 0 is on top.
- Pixel colour:
  - Winning sprite colour when any sprite hits.
  - `BG_COLOR` when none hits.
  - 8'h00 whenever the delayed `video_enable` is 0.
- Pipeline:
  - S1 registers the inputs and per-sprite dx/dy/in-range flags.
  - S2 selects bitmap bits, resolves priority and registers `rgb`.
  - Sync and `video_enable` go through a matching 2-deep delay.

## Timing
- Latency: input at edge n appears on `rgb`/`hsync_out`/`vsync_out` after edge n+2.
- Reset values:
  - `rgb`, `hsync_out`, `vsync_out`, pipeline registers: 0.
  - All shadow and active X/Y/colour/enable/bitmaps: 0.
  - `wr_ready`: 0 while in reset.
- Write visibility:
  - Shadow writes take effect on the first commit strictly after acceptance.
  - A write presented in the commit cycle stalls one cycle and lands after the copy, so it is not visible until the next frame.
  - Bitmap writes are visible two cycles after acceptance, mid-frame if written during scan.
- Reset asserted mid-frame clears everything immediately. After release the pipeline refills in 2 cycles.
- Two writes to the same register in consecutive cycles: the last write wins.

## Structure
- Shared package `vga_pkg`:
  - timing constants `HD`, `VD`
  - offsets `OFS_X` = 16, `OFS_Y` = 17, `OFS_ATTR` = 18
  - `SPRITE_W` = `SPRITE_H` = 16
  - RGB332 field positions
- Sub-module `sprite_unit`, instantiated 4 times: holds one sprite's shadow/active registers and bitmap, and produces the registered hit flag and colour. The top level holds the priority mux, delay line and write decode.

## Test plan
- Reset released with no writes -> `rgb` = `BG_COLOR` in the active area, 0 in blanking; `hsync_out`/`vsync_out` equal the inputs delayed by exactly 2 clocks.
- Sprite 0: all bitmap rows 16'hFFFF, X=100, Y=50, colour 8'hE0, enable 1, written during line 10 -> unchanged until the commit at line 480. In the next frame, `rgb` = 8'hE0 exactly for x 100..115, y 50..65, and background elsewhere.
- Sprites 0 and 1 overlap at (200,200), colours 8'h1C and 8'h03 -> overlap pixels read 8'h1C; sprite-1-only pixels read 8'h03.
- Sprite at X=632 -> colour only at x 632..639. No wrap to x 0..7; `rgb` = 0 in blanking.
- `wr_valid` held at `pixel_x=0`, `pixel_y=480` -> `wr_ready` low for that one cycle, write accepted the next cycle, and it takes effect after the following frame's commit.
- Reset pulsed mid-frame at line 240 -> all outputs 0 during reset; sprites disabled afterwards; background only until new writes are committed.
